// File: rtl/count_leading_ones_pkg.sv
// Shared defaults and the saturating run-length helper for the leading-ones counter.
// Optional leading-zeros outputs are enabled by defining CLS_LEADING_ZEROS_EN.
package count_leading_ones_pkg;

  localparam int CLS_DEFAULT_N = 8;

  // Run length from the MSB given the highest breaking bit; saturates to n-1 when nothing breaks it.
  function automatic int cls_run_length(input int n, input int h, input logic found);
    return found ? (n - 1 - h) : (n - 1);
  endfunction

endpackage

// File: rtl/count_leading_ones_if.sv
// Request/result bundle for count_leading_ones; the DUT side uses the slave modport.
// The leading_zeros/all_zeros members exist only when CLS_LEADING_ZEROS_EN is defined.
interface count_leading_ones_if #(
  parameter int N = 8,
  parameter int S = $clog2(N)
);

  logic         in_valid;
  logic [N-1:0] bits;
  logic         out_valid;
  logic [S-1:0] leading_ones;
  logic [S-1:0] index_highest_set;
  logic         all_ones;
`ifdef CLS_LEADING_ZEROS_EN
  logic [S-1:0] leading_zeros;
  logic         all_zeros;

  modport master (
    output in_valid, bits,
    input  out_valid, leading_ones, index_highest_set, all_ones, leading_zeros, all_zeros
  );
  modport slave (
    input  in_valid, bits,
    output out_valid, leading_ones, index_highest_set, all_ones, leading_zeros, all_zeros
  );
`else
  modport master (
    output in_valid, bits,
    input  out_valid, leading_ones, index_highest_set, all_ones
  );
  modport slave (
    input  in_valid, bits,
    output out_valid, leading_ones, index_highest_set, all_ones
  );
`endif

endinterface

// File: rtl/count_leading_ones_highest_set.sv
// highest_set: parameterised priority encoder returning the index of the highest set bit
// of vec plus a found flag (index is 0 when vec is all zeros).
module highest_set #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [SW-1:0] index,
  output logic          found
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        index = i[SW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_leading_ones.sv
// count_leading_ones: registered count of consecutive 1s from the MSB, latency 1.
// Define CLS_LEADING_ZEROS_EN to add the leading_zeros/all_zeros outputs.
module count_leading_ones
  import count_leading_ones_pkg::*;
#(
  parameter int N = CLS_DEFAULT_N,
  parameter int S = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  count_leading_ones_if.slave  bus
);

  logic [N-1:0] inverted;
  logic [S-1:0] zero_idx;
  logic         zero_found;
  logic [S-1:0] ones_next;
  logic [S-1:0] index_next;

  assign inverted = ~bus.bits;

  // The first 0 below the MSB breaks the run of ones, so encode ~bits.
  highest_set #(.W(N), .SW(S)) u_zero_scan (
    .vec   (inverted),
    .index (zero_idx),
    .found (zero_found)
  );

  assign ones_next  = S'(cls_run_length(N, int'(zero_idx), zero_found));
  assign index_next = zero_found ? zero_idx : '0;

`ifdef CLS_LEADING_ZEROS_EN
  logic [S-1:0] one_idx;
  logic         one_found;
  logic [S-1:0] zeros_next;

  highest_set #(.W(N), .SW(S)) u_one_scan (
    .vec   (bus.bits),
    .index (one_idx),
    .found (one_found)
  );

  assign zeros_next = S'(cls_run_length(N, int'(one_idx), one_found));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.leading_zeros <= '0;
      bus.all_zeros     <= 1'b0;
    end else if (bus.in_valid) begin
      bus.leading_zeros <= zeros_next;
      bus.all_zeros     <= ~one_found;
    end
  end
`endif

  // Results hold between valid inputs; out_valid tracks in_valid one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid         <= 1'b0;
      bus.leading_ones      <= '0;
      bus.index_highest_set <= '0;
      bus.all_ones          <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.leading_ones      <= ones_next;
        bus.index_highest_set <= index_next;
        bus.all_ones          <= ~zero_found;
      end
    end
  end

endmodule

// File: tb/tb_count_leading_ones.sv
// Bench for count_leading_ones: drives N=8 and N=16 instances in lockstep and checks them
// against directed tables and a run-length reference model (CLS_LEADING_ZEROS_EN aware).
module tb_count_leading_ones;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  count_leading_ones_if #(.N(8))  bus8 ();
  count_leading_ones_if #(.N(16)) bus16 ();

  count_leading_ones #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  count_leading_ones #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    int v;
    int lo;
    int idx;
    int ao;
    int lz;
    int az;
  } exp_t;

  typedef struct {
    logic [7:0]  b8;
    int          lo8;
    int          idx8;
    int          all8;
    logic [15:0] b16;
    int          lo16;
    int          idx16;
    int          all16;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t e8;
  exp_t e16;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: count the run from the MSB directly, then apply the saturation rule.
  function automatic exp_t model(input logic [15:0] b, input int n, input int v);
    exp_t r;
    int   ones  = 0;
    int   zeros = 0;
    while (ones < n && b[n-1-ones] == 1'b1) ones++;
    while (zeros < n && b[n-1-zeros] == 1'b0) zeros++;
    r.v   = v;
    r.lo  = (ones == n) ? n - 1 : ones;
    r.idx = (ones == n) ? 0 : n - 1 - ones;
    r.ao  = (ones == n) ? 1 : 0;
    r.lz  = (zeros == n) ? n - 1 : zeros;
    r.az  = (zeros == n) ? 1 : 0;
    return r;
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b8, input logic [15:0] b16);
    @(negedge clk);
    rst            = r;
    bus8.in_valid  = v;
    bus8.bits      = b8;
    bus16.in_valid = v;
    bus16.bits     = b16;
    @(posedge clk);
    #1;
    if (r) begin
      e8  = '{default: 0};
      e16 = '{default: 0};
    end else if (v) begin
      e8  = model({8'h00, b8}, 8, 1);
      e16 = model(b16, 16, 1);
    end else begin
      e8.v  = 0;
      e16.v = 0;
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " valid8"}, 32'(bus8.out_valid), e8.v);
    check({tag, " lo8"},    32'(bus8.leading_ones), e8.lo);
    check({tag, " idx8"},   32'(bus8.index_highest_set), e8.idx);
    check({tag, " all8"},   32'(bus8.all_ones), e8.ao);
    check({tag, " valid16"}, 32'(bus16.out_valid), e16.v);
    check({tag, " lo16"},   32'(bus16.leading_ones), e16.lo);
    check({tag, " idx16"},  32'(bus16.index_highest_set), e16.idx);
    check({tag, " all16"},  32'(bus16.all_ones), e16.ao);
`ifdef CLS_LEADING_ZEROS_EN
    check({tag, " lz8"},  32'(bus8.leading_zeros), e8.lz);
    check({tag, " az8"},  32'(bus8.all_zeros), e8.az);
    check({tag, " lz16"}, 32'(bus16.leading_zeros), e16.lz);
    check({tag, " az16"}, 32'(bus16.all_zeros), e16.az);
`endif
  endtask

  initial begin
    vec_t        table_v[6];
    logic [15:0] mask;
    logic [15:0] b16;
    logic [31:0] r;
    int          k;

    table_v[0] = '{8'hE5, 3, 4, 0, 16'hFFFE, 15, 0, 0};
    table_v[1] = '{8'h7F, 0, 7, 0, 16'hFFFF, 15, 0, 1};
    table_v[2] = '{8'hFF, 7, 0, 1, 16'h7FFF, 0, 15, 0};
    table_v[3] = '{8'h80, 1, 6, 0, 16'hF0F0, 4, 11, 0};
    table_v[4] = '{8'hFE, 7, 0, 0, 16'h8000, 1, 14, 0};
    table_v[5] = '{8'h00, 0, 7, 0, 16'hC003, 2, 13, 0};

    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.bits      = '0;
    bus16.in_valid = 1'b0;
    bus16.bits     = '0;
    e8  = '{default: 0};
    e16 = '{default: 0};

    // Reset with in_valid high: everything must read back as zero.
    applyStimulus(1'b1, 1'b1, 8'hFF, 16'hFFFF);
    check("reset valid8", 32'(bus8.out_valid), 0);
    check("reset lo8",    32'(bus8.leading_ones), 0);
    check("reset idx8",   32'(bus8.index_highest_set), 0);
    check("reset all8",   32'(bus8.all_ones), 0);
    check("reset valid16", 32'(bus16.out_valid), 0);
    check("reset lo16",   32'(bus16.leading_ones), 0);

    foreach (table_v[i]) begin
      applyStimulus(1'b0, 1'b1, table_v[i].b8, table_v[i].b16);
      check($sformatf("row%0d valid8", i), 32'(bus8.out_valid), 1);
      check($sformatf("row%0d lo8", i),    32'(bus8.leading_ones), table_v[i].lo8);
      check($sformatf("row%0d idx8", i),   32'(bus8.index_highest_set), table_v[i].idx8);
      check($sformatf("row%0d all8", i),   32'(bus8.all_ones), table_v[i].all8);
      check($sformatf("row%0d lo16", i),   32'(bus16.leading_ones), table_v[i].lo16);
      check($sformatf("row%0d idx16", i),  32'(bus16.index_highest_set), table_v[i].idx16);
      check($sformatf("row%0d all16", i),  32'(bus16.all_ones), table_v[i].all16);
    end

    // Back-to-back inputs must produce one result per cycle.
    applyStimulus(1'b0, 1'b1, 8'h80, 16'h8000);
    check("b2b0 valid8", 32'(bus8.out_valid), 1);
    check("b2b0 lo8", 32'(bus8.leading_ones), 1);
    applyStimulus(1'b0, 1'b1, 8'hC0, 16'hC000);
    check("b2b1 valid8", 32'(bus8.out_valid), 1);
    check("b2b1 lo8", 32'(bus8.leading_ones), 2);
    applyStimulus(1'b0, 1'b1, 8'hE0, 16'hE000);
    check("b2b2 valid8", 32'(bus8.out_valid), 1);
    check("b2b2 lo8", 32'(bus8.leading_ones), 3);
    check("b2b2 lo16", 32'(bus16.leading_ones), 3);

    // Idle cycle: results hold while out_valid drops.
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    check("hold valid8", 32'(bus8.out_valid), 0);
    check("hold lo8", 32'(bus8.leading_ones), 3);
    check("hold idx8", 32'(bus8.index_highest_set), 4);

    // Reset mid-stream discards the in-flight result.
    applyStimulus(1'b0, 1'b1, 8'hE5, 16'hFFFE);
    applyStimulus(1'b1, 1'b1, 8'hFF, 16'hFFFF);
    check("midrst valid8", 32'(bus8.out_valid), 0);
    check("midrst lo8", 32'(bus8.leading_ones), 0);
    check("midrst idx8", 32'(bus8.index_highest_set), 0);
    check("midrst lo16", 32'(bus16.leading_ones), 0);
    applyStimulus(1'b0, 1'b0, 8'hFF, 16'hFFFF);
    check("postrst valid8", 32'(bus8.out_valid), 0);
    check("postrst all8", 32'(bus8.all_ones), 0);

`ifdef CLS_LEADING_ZEROS_EN
    applyStimulus(1'b0, 1'b1, 8'h10, 16'h0100);
    check("lz 10 lz8", 32'(bus8.leading_zeros), 3);
    check("lz 10 az8", 32'(bus8.all_zeros), 0);
    check("lz 0100 lz16", 32'(bus16.leading_zeros), 7);
    applyStimulus(1'b0, 1'b1, 8'h00, 16'h0000);
    check("lz 00 lz8", 32'(bus8.leading_zeros), 7);
    check("lz 00 az8", 32'(bus8.all_zeros), 1);
    check("lz 0000 lz16", 32'(bus16.leading_zeros), 15);
    check("lz 0000 az16", 32'(bus16.all_zeros), 1);
`endif

    // Exhaustive N=8 sweep, with random 16-bit words alongside.
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      applyStimulus(1'b0, 1'b1, i[7:0], r[15:0]);
      checkOutput($sformatf("sweep%0d", i));
    end

    // Random traffic biased toward long runs of ones or zeros from the MSB.
    for (int i = 0; i < 400; i++) begin
      r    = $urandom;
      k    = $urandom_range(0, 16);
      mask = 16'hFFFF;
      mask = mask << (16 - k);
      b16  = r[31] ? (r[15:0] | mask) : (r[15:0] & ~mask);
      applyStimulus(r[30:29] == 2'b00 && r[28], r[27:26] != 2'b00, b16[15:8], b16);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
